// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame capture and optional blink.
// Define SSD_BLINK_EN to enable per-digit blinking; otherwise digits are shown continuously.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd,
  input  logic [3:0]  blink,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [19:0] FRAME_BLANK = {4{5'h10}};

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    slot_q, slot_d;
  logic          start_q, start_d;
  logic [19:0]   frame_q, frame_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          slot_adv;
  logic          frame_start;
  logic [19:0]   disp;
  logic [4:0]    code;

  // Active-high segment pattern {g,f,e,d,c,b,a}; inverted at the output.
  function automatic logic [6:0] decode(input logic [4:0] c);
    case (c)
      5'h00:   decode = 7'h3F;
      5'h01:   decode = 7'h06;
      5'h02:   decode = 7'h5B;
      5'h03:   decode = 7'h4F;
      5'h04:   decode = 7'h66;
      5'h05:   decode = 7'h6D;
      5'h06:   decode = 7'h7D;
      5'h07:   decode = 7'h07;
      5'h08:   decode = 7'h7F;
      5'h09:   decode = 7'h6F;
      5'h0A:   decode = 7'h77;
      5'h0B:   decode = 7'h7C;
      5'h0C:   decode = 7'h39;
      5'h0D:   decode = 7'h5E;
      5'h0E:   decode = 7'h79;
      5'h0F:   decode = 7'h71;
      5'h11:   decode = 7'h38;
      5'h12:   decode = 7'h5E;
      5'h13:   decode = 7'h73;
      5'h14:   decode = 7'h54;
      default: decode = 7'h00;
    endcase
  endfunction

`ifdef SSD_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    fblink_q, fblink_d;
  logic [3:0]    dblink;

  always_comb begin
    bcnt_d   = (bcnt_q == B_LAST) ? '0 : bcnt_q + BW'(1);
    phase_d  = (bcnt_q == B_LAST) ? ~phase_q : phase_q;
    fblink_d = frame_start ? blink : fblink_q;
    dblink   = (slot_q == 2'd3) ? fblink_d : fblink_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
      fblink_q <= 4'b0000;
    end else begin
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      fblink_q <= fblink_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^blink;
`endif

  always_comb begin
    slot_adv    = (rcnt_q == R_LAST);
    rcnt_d      = slot_adv ? '0 : rcnt_q + RW'(1);
    slot_d      = slot_adv ? slot_q - 2'd1 : slot_q;
    start_d     = 1'b0;
    frame_start = start_q | (slot_adv & (slot_q == 2'd0));
    frame_d     = frame_start ? ssd : frame_q;
    // Capture only happens while slot_q is 3 (post-reset) or 0 (frame wrap), so slot 3 may
    // read the just-captured frame while slot 0 keeps the old one -- no tearing either way.
    disp        = (slot_q == 2'd3) ? frame_d : frame_q;
    case (slot_q)
      2'd3:    code = disp[19:15];
      2'd2:    code = disp[14:10];
      2'd1:    code = disp[9:5];
      default: code = disp[4:0];
    endcase
    seg_d = ~decode(code);
`ifdef SSD_BLINK_EN
    if (dblink[slot_q] && !phase_q) seg_d = 7'h7F;
`endif
    an_d = ~(4'b0001 << slot_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q  <= '0;
      slot_q  <= 2'd3;
      start_q <= 1'b1;
      frame_q <= FRAME_BLANK;
      seg_q   <= 7'h7F;
      an_q    <= 4'b1111;
    end else begin
      rcnt_q  <= rcnt_d;
      slot_q  <= slot_d;
      start_q <= start_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule
